// File: rtl/sc_out_port_display_if.sv
// Bundle of the value/display signals of one out-port display.
// Handshake: update is a one-cycle strobe, high in the single cycle in which
// overflow/hex0..hex5 first present a new conversion result; those outputs
// hold steady until the next strobe. busy is high while a conversion is
// pending and in_value changes during that time are not captured.
interface sc_out_port_display_if;
    logic [31:0] in_value;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic [6:0]  hex4;
    logic [6:0]  hex5;
    logic        busy;
    logic        update;
    logic        overflow;
    logic [1:0]  dbg_state;

    // Producer side: supplies the port value, observes the display
    modport master (
        output in_value,
        input  hex0, hex1, hex2, hex3, hex4, hex5,
        input  busy, update, overflow, dbg_state
    );

    // Display side
    modport slave (
        input  in_value,
        output hex0, hex1, hex2, hex3, hex4, hex5,
        output busy, update, overflow, dbg_state
    );
endinterface

// File: rtl/sc_out_port_display.sv
// Six-digit 7-segment display of a 32-bit CPU out-port value.
// A sequential double-dabble engine converts one bit per clock, and runs
// only when the port value differs from the last value converted.
module sc_out_port_display #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetn,
    sc_out_port_display_if.slave  port
);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    // Value shown on hex1..hex5 while nothing has been converted yet
    localparam logic [6:0] SEG_RST_HI = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [31:0]      last_value_q;
    logic [31:0]      shift_q;
    logic [39:0]      bcd_q;
    logic [4:0]       cnt_q;
    logic [5:0][6:0]  hex_q;
    logic             overflow_q;
    logic             busy_q;
    logic             update_q;

    logic [39:0]      bcd_adj_d;
    logic [5:0][6:0]  hex_d;
    logic             overflow_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_DASH;
        endcase
    endfunction

    // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj_d = bcd_q;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Segment codes for the finished result, with leading-zero blanking
    // scanning down from digit 5; hex0 always shows its digit.
    always_comb begin
        logic lead;
        lead       = 1'b1;
        hex_d      = '0;
        overflow_d = |bcd_q[39:24];
        for (int i = 5; i >= 1; i--) begin
            if (bcd_q[i*4 +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            hex_d[i] = (lead && BLANK_LEADING) ? SEG_BLANK : seg7(bcd_q[i*4 +: 4]);
        end
        hex_d[0] = seg7(bcd_q[3:0]);
        if (overflow_d) begin
            hex_d = {6{SEG_DASH}};
        end
    end

    // Conversion FSM with registered display outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_value_q <= '0;
            shift_q      <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            hex_q        <= {{5{SEG_RST_HI}}, SEG_ZERO};
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            update_q     <= 1'b0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (port.in_value != last_value_q) begin
                        shift_q      <= port.in_value;
                        last_value_q <= port.in_value;
                        bcd_q        <= '0;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj_d[38:0], shift_q, 1'b0};
                    cnt_q            <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    hex_q      <= hex_d;
                    overflow_q <= overflow_d;
                    update_q   <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign port.hex0      = hex_q[0];
    assign port.hex1      = hex_q[1];
    assign port.hex2      = hex_q[2];
    assign port.hex3      = hex_q[3];
    assign port.hex4      = hex_q[4];
    assign port.hex5      = hex_q[5];
    assign port.overflow  = overflow_q;
    assign port.busy      = busy_q;
    assign port.update    = update_q;
    assign port.dbg_state = state_q;

endmodule

// File: tb/tb_sc_out_port_display.sv
// Bench for sc_out_port_display: one instance with leading-zero blanking and
// one without, driven with the same port value.
module tb_sc_out_port_display;

    logic clock;
    logic resetn;

    sc_out_port_display_if ifb ();
    sc_out_port_display_if ifz ();

    sc_out_port_display #(.BLANK_LEADING(1'b1)) dut_b (
        .clock  (clock),
        .resetn (resetn),
        .port   (ifb)
    );

    sc_out_port_display #(.BLANK_LEADING(1'b0)) dut_z (
        .clock  (clock),
        .resetn (resetn),
        .port   (ifz)
    );

    // Clock / watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    int n_vec  = 0;
    int n_miss = 0;

    logic [42:0] exp_b_q[$];
    logic [42:0] exp_z_q[$];

    // Reference model: display contents from decimal arithmetic
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'bxxxxxxx;
        endcase
    endfunction

    // {overflow, hex5, hex4, hex3, hex2, hex1, hex0}
    function automatic logic [42:0] model_display(input logic [31:0] v, input bit blank);
        logic [42:0] r;
        longint unsigned p;
        longint unsigned lv;
        lv = v;
        if (lv > 999999) return {1'b1, {6{7'b0111111}}};
        r = '0;
        p = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0 && blank && lv < p) r[i*7 +: 7] = 7'b1111111;
            else                          r[i*7 +: 7] = seg_of(int'((lv / p) % 10));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [42:0] obs_b();
        return {ifb.overflow, ifb.hex5, ifb.hex4, ifb.hex3, ifb.hex2, ifb.hex1, ifb.hex0};
    endfunction

    function automatic logic [42:0] obs_z();
        return {ifz.overflow, ifz.hex5, ifz.hex4, ifz.hex3, ifz.hex2, ifz.hex1, ifz.hex0};
    endfunction

    task automatic check43(input string name, input logic [42:0] act, input logic [42:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop on every update strobe
    always @(negedge clock) begin
        if (ifb.update) begin
            if (exp_b_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_update_b: got update=1, expected none at %0t", $time);
            end else begin
                check43("display_b", obs_b(), exp_b_q.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (ifz.update) begin
            if (exp_z_q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_update_z: got update=1, expected none at %0t", $time);
            end else begin
                check43("display_z", obs_z(), exp_z_q.pop_front());
            end
        end
    end

    // Driver tasks
    logic [31:0] cur_value;

    task automatic set_value(input logic [31:0] v, input bit push);
        ifb.in_value = v;
        ifz.in_value = v;
        cur_value    = v;
        if (push) begin
            exp_b_q.push_back(model_display(v, 1'b1));
            exp_z_q.push_back(model_display(v, 1'b0));
        end
    endtask

    // Counts falling edges until the update strobe is seen; start lets the
    // count continue from cycles already spent by the caller.
    task automatic wait_update(input int start, input bit check_busy, output int cyc, output bit seen);
        cyc  = start;
        seen = 1'b0;
        while (!seen && cyc < 120) begin
            @(negedge clock);
            cyc++;
            if (check_busy && cyc == 1) check_int("busy_after_capture", int'(ifb.busy), 1);
            if (ifb.update) seen = 1'b1;
        end
    endtask

    // Capture edge is the first rising edge after the value is driven; the
    // strobe is seen on the falling edge 33 clocks after that, i.e. count 34.
    task automatic apply_and_wait(input logic [31:0] v);
        int cyc;
        bit seen;
        set_value(v, 1'b1);
        wait_update(0, 1'b1, cyc, seen);
        check_int("latency", seen ? cyc : -1, 34);
        check_int("busy_clear_at_update", int'(ifb.busy), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check43({"reset_disp_b_", tag}, obs_b(), model_display(32'd0, 1'b1));
        check43({"reset_disp_z_", tag}, obs_z(), model_display(32'd0, 1'b0));
        check_int({"reset_busy_", tag}, int'(ifb.busy | ifz.busy), 0);
        check_int({"reset_update_", tag}, int'(ifb.update | ifz.update), 0);
    endtask

    task automatic watch_no_update(input int n, input string name);
        int seen_cnt;
        seen_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (ifb.update || ifz.update) seen_cnt++;
        end
        check_int(name, seen_cnt, 0);
    endtask

    logic [31:0] vals[$];

    initial begin
        int cyc;
        bit seen;
        logic [31:0] v;

        // Reset block
        resetn = 1'b0;
        set_value(32'd0, 1'b0);
        repeat (3) @(negedge clock);
        check_reset_state("hold");
        resetn = 1'b1;

        // Idle at zero: no conversion, no strobe
        watch_no_update(50, "no_update_zero");
        check_reset_state("idle");

        // Directed values and boundaries
        vals = '{32'd123456, 32'd7, 32'd999999, 32'd1000000, 32'hFFFFFFFF,
                 32'd0, 32'd10, 32'd100000, 32'd90};
        foreach (vals[i]) apply_and_wait(vals[i]);

        // Value changes mid-conversion: second value picked up afterwards
        set_value(32'd42, 1'b1);
        exp_b_q.push_back(model_display(32'd305, 1'b1));
        exp_z_q.push_back(model_display(32'd305, 1'b0));
        repeat (10) @(negedge clock);
        set_value(32'd305, 1'b0);
        wait_update(10, 1'b0, cyc, seen);
        check_int("latency_first_of_two", seen ? cyc : -1, 34);
        wait_update(0, 1'b0, cyc, seen);
        check_int("latency_recapture", seen ? cyc : -1, 34);

        // Value changes and returns while busy: no reconversion
        set_value(32'd2024, 1'b1);
        repeat (5) @(negedge clock);
        set_value(32'd77, 1'b0);
        repeat (5) @(negedge clock);
        set_value(32'd2024, 1'b0);
        wait_update(10, 1'b0, cyc, seen);
        check_int("latency_bounce", seen ? cyc : -1, 34);
        watch_no_update(45, "no_reconvert_on_return");

        // Reset mid-conversion
        set_value(32'd555, 1'b0);
        repeat (15) @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_state("async");
        exp_b_q.delete();
        exp_z_q.delete();
        repeat (3) @(negedge clock);
        check_reset_state("mid_hold");
        exp_b_q.push_back(model_display(32'd555, 1'b1));
        exp_z_q.push_back(model_display(32'd555, 1'b0));
        resetn = 1'b1;
        wait_update(0, 1'b1, cyc, seen);
        check_int("latency_after_reset", seen ? cyc : -1, 34);

        // Randomized values across digit-count ranges
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(0, 999999);
                2:       v = $urandom_range(999000, 1001000);
                default: v = $urandom;
            endcase
            if (v == cur_value) v = v ^ 32'd1;
            apply_and_wait(v);
        end

        repeat (5) @(negedge clock);
        check_int("queue_b_drained", exp_b_q.size(), 0);
        check_int("queue_z_drained", exp_z_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sc_out_port_display.md
Name: sc_out_port_display

Overview:
- Downstream consumer of the CPU top's 32-bit output ports (one instance per out_port0..2).
- Converts an unsigned binary port value to 6 decimal digits using a sequential double-dabble engine, one bit per clock.
- Drives six active-low 7-segment digits (board HEX5..HEX0).
- Conversion runs only when the port value changes, so displays update cleanly without a wide combinational divider.

Parameters:
BLANK_LEADING, 1, 1 = leading-zero digits above hex0 show blank (7'b1111111); 0 = they show "0".

Ports:
clock     input   1   system clock; all state updates on its rising edge
resetn    input   1   asynchronous active-low reset
in_value  input   32  unsigned value from a CPU out_port
hex0      output  7   least significant digit segments, active-low, bit0=a .. bit6=g
hex1      output  7   digit 1
hex2      output  7   digit 2
hex3      output  7   digit 3
hex4      output  7   digit 4
hex5      output  7   most significant digit
busy      output  1   1 while a conversion is in progress (state != IDLE)
update    output  1   one-cycle pulse when hex0..hex5/overflow take new values
overflow  output  1   1 when the displayed value is > 999999

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; last_value=0; shift/BCD/count registers=0.
  - hex0=7'b1000000; hex1..hex5=7'b1111111 if BLANK_LEADING=1, else 7'b1000000.
  - overflow=0, busy=0, update=0.
  - Reset mid-conversion aborts the conversion immediately. No update pulse follows release of reset for in_value=0.
- Segment codes (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: when in_value != last_value on edge E0: shift_reg<=in_value, last_value<=in_value, bcd (10 digits, 40 bits)<=0, cnt<=0, go to SHIFT. Otherwise stay.
  - SHIFT, one iteration per edge (E1..E32):
    - Every BCD digit >= 5 gets +3.
    - Then {bcd,shift_reg} shifts left by 1.
    - cnt increments.
    - At cnt==31 (edge E32), go to DONE.
  - DONE, edge E33:
    - If bcd digits 9..6 are all zero: overflow<=0, hex0..hex5 <= codes of digits 0..5. Leading-zero blanking applies to digits 5..1 above the highest nonzero digit; hex0 is never blanked.
    - Otherwise overflow<=1 and all six digits show dash.
    - update<=1 for exactly this cycle; go to IDLE.
- Latency: outputs are valid and update is high in the cycle after edge E33, i.e. 33 clocks after the capture edge. busy=1 after E0 through the cycle ending at E33.
- in_value changes while busy are ignored. On return to IDLE the comparison against last_value re-runs, so the latest value is always eventually displayed. A value that changes and returns to last_value while busy triggers no reconversion.
- hex outputs hold their values between updates. No glitches: all outputs are registered.
- Arithmetic is unsigned 32-bit. The full 10-digit BCD result fits in 40 bits; 0xFFFFFFFF gives overflow.

Test Plan:
- Reset, in_value=0 held 50 clocks -> hex0=1000000, hex1..5=1111111, update never pulses, busy=0.
- in_value=123456 -> update pulses exactly 33 clocks after the capture edge. Then hex5..hex0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010; overflow=0.
- in_value=7 -> hex0=1111000, hex1..5=1111111 (BLANK_LEADING=1). Rerun with BLANK_LEADING=0 -> hex1..5=1000000.
- Boundary values:
  - in_value=999999 -> all digits 0010000, overflow=0.
  - in_value=1000000 -> all digits 0111111, overflow=1.
  - in_value=32'hFFFFFFFF -> overflow=1.
- in_value=42, then changed to 305 ten clocks into the conversion:
  - First update shows hex1=0011001, hex0=0100100.
  - Next IDLE cycle recaptures; second update 34 clocks after the first shows 305 (hex2=0110000, hex1=1000000, hex0=0010010).
- in_value=555, resetn pulsed low at clock 15 of the conversion -> outputs return to reset values asynchronously, no update pulse. After release, conversion of 555 restarts and shows 0010010 x3 after 33 clocks.
